// File: rtl/bc_spi_tx.sv
// bc_spi_tx: pops breadcrumb words over valid/ready and sends each as one SPI mode-0 frame, MSB first.
// Define BC_SPI_PARITY_EN to append an odd-parity bit (~^word) after the data LSB.
module bc_spi_tx #(
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              sck_out,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done
);

`ifdef BC_SPI_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int NBITS  = DATA_W + PAR_BITS;
  localparam int REST_W = NBITS - 1;
  localparam int BIT_W  = $clog2(NBITS + 1);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam bit NO_GAP = (GAP_CYCLES == 0);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  // Bits that follow the MSB on the wire; the MSB itself goes straight to mosi on accept.
  function automatic logic [REST_W-1:0] tail_bits(input logic [DATA_W-1:0] w);
`ifdef BC_SPI_PARITY_EN
    return {w[DATA_W-2:0], ~^w};
`else
    return w[DATA_W-2:0];
`endif
  endfunction

  logic [1:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [REST_W-1:0] shift_q, shift_d;

  // Next-state logic: handshake, sck divider, bit sequencing and inter-frame gap.
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shift_d = shift_q;

    case (state_q)
      S_IDLE: begin
        if (word_valid && ready_q) begin
          state_d = S_SHIFT;
          ready_d = 1'b0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          sck_d   = 1'b0;
          mosi_d  = word_in[DATA_W-1];
          shift_d = tail_bits(word_in);
          div_d   = '0;
          bit_d   = '0;
        end else begin
          ready_d = 1'b1;
        end
      end

      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            bit_d = bit_q + BIT_W'(1);
          end else begin
            sck_d = 1'b0;
            // The fall after the final rise closes the frame.
            if (bit_q == BIT_LAST) begin
              cs_n_d = 1'b1;
              mosi_d = 1'b0;
              done_d = 1'b1;
              gap_d  = '0;
              if (NO_GAP) begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
              end else begin
                state_d = S_GAP;
              end
            end else begin
              mosi_d  = shift_q[REST_W-1];
              shift_d = shift_q << 1'b1;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        gap_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
    end
  end

  assign word_ready = ready_q;
  assign sck_out    = sck_q;
  assign mosi       = mosi_q;
  assign cs_n       = cs_n_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
